// File: rtl/axi_read_arbiter_pkg.sv
// axi_rd_arb_pkg: shared state/requester types and AXI encodings for the read arbiter
package axi_rd_arb_pkg;
  typedef enum logic [1:0] {IDLE, AR, DATA} arb_state_e;
  typedef enum logic {REQ_IF = 1'b0, REQ_MEM = 1'b1} requester_e;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B = 3'b011;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
endpackage

// File: rtl/axi_read_arbiter_if.sv
// axi_read_arbiter_if: AXI read address/data channels shared by the arbiter and the bus
interface axi_read_arbiter_if #(
  parameter int ID_WIDTH = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic [ID_WIDTH-1:0] arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic arlock;
  logic [3:0] arcache;
  logic [2:0] arprot;
  logic arvalid;
  logic arready;
  logic [ID_WIDTH-1:0] rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0] rresp;
  logic rlast;
  logic rvalid;
  logic rready;
  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    input arready, rid, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: round-robin share of one AXI read channel between IF and MEM line fills
module axi_read_arbiter
  import axi_rd_arb_pkg::*;
#(
  parameter int ID_WIDTH = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN = 8,
  localparam int BEAT_W = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic mem_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] if_data,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic if_data_valid,
  output logic mem_data_valid,
  output logic [BEAT_W-1:0] if_beat,
  output logic [BEAT_W-1:0] mem_beat,
  output logic if_done,
  output logic mem_done,
  output logic if_err,
  output logic mem_err,
  axi_read_arbiter_if.master m_axi
);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  arb_state_e state, state_nx;
  requester_e owner, rr_last, pick;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BEAT_W-1:0] cnt;
  logic err_flag, id_hit, acc, done, err;
  // on a tie the requester served last time yields
  assign pick = (if_req && mem_req) ? (rr_last == REQ_IF ? REQ_MEM : REQ_IF) : (mem_req ? REQ_MEM : REQ_IF);
  assign id_hit = m_axi.rid == ID_WIDTH'(owner);
  assign acc = state == DATA && m_axi.rvalid && id_hit;
  assign done = acc && m_axi.rlast;
  assign err = err_flag || m_axi.rresp != AXI_RESP_OKAY || cnt != LAST_BEAT;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      owner <= REQ_IF;
      rr_last <= REQ_IF;
      addr_q <= '0;
      cnt <= '0;
      err_flag <= 1'b0;
    end else begin
      if (state == IDLE && (if_req || mem_req)) begin
        owner <= pick;
        addr_q <= (pick == REQ_MEM ? mem_addr : if_addr) & ~ADDR_WIDTH'(BURST_LEN * 8 - 1);
      end
      if (state == AR && m_axi.arready) begin
        cnt <= '0;
        err_flag <= 1'b0;
      end
      if (acc) cnt <= cnt == LAST_BEAT ? '0 : cnt + 1'b1;
      // foreign-ID beats are swallowed but poison the burst status
      if (state == DATA && m_axi.rvalid) err_flag <= err_flag || !id_hit || m_axi.rresp != AXI_RESP_OKAY;
      if (done) rr_last <= owner;
    end
  always_comb
    state_nx = state == IDLE ? (if_req || mem_req ? AR : IDLE) :
               state == AR   ? (m_axi.arready ? DATA : AR) :
               state == DATA && !done ? DATA : IDLE;
  always_comb begin
    m_axi.arid = ID_WIDTH'(owner);
    m_axi.araddr = addr_q;
    m_axi.arlen = 8'(BURST_LEN - 1);
    m_axi.arsize = AXI_SIZE_8B;
    m_axi.arburst = AXI_BURST_INCR;
    m_axi.arlock = 1'b0;
    m_axi.arcache = 4'b0000;
    m_axi.arprot = 3'b000;
    m_axi.arvalid = state == AR;
    m_axi.rready = state == DATA;
    if_data_valid = acc && owner == REQ_IF;
    mem_data_valid = acc && owner == REQ_MEM;
    if_data = if_data_valid ? m_axi.rdata : '0;
    mem_data = mem_data_valid ? m_axi.rdata : '0;
    if_beat = if_data_valid ? cnt : '0;
    mem_beat = mem_data_valid ? cnt : '0;
    if_done = if_data_valid && m_axi.rlast;
    mem_done = mem_data_valid && m_axi.rlast;
    if_err = if_done && err;
    mem_err = mem_done && err;
  end
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: randomized scoreboard bench for the IF/MEM AXI read arbiter
module tb_axi_read_arbiter;
  localparam int BL = 8;
  typedef struct { int own; logic [63:0] data; int idx; bit last; bit err; } beat_t;
  typedef struct { int id; logic [63:0] addr; } ar_t;
  logic clk = 0, reset = 0, if_req = 0, mem_req = 0;
  logic [63:0] if_addr = 0, mem_addr = 0, if_data, mem_data;
  logic if_data_valid, mem_data_valid, if_done, mem_done, if_err, mem_err;
  logic [2:0] if_beat, mem_beat;
  int checks = 0, fails = 0, model_last = 0;
  beat_t beat_q[$];
  ar_t ar_q[$];
  axi_read_arbiter_if m_axi();
  axi_read_arbiter dut (
    .clk(clk), .reset(reset), .if_req(if_req), .mem_req(mem_req),
    .if_addr(if_addr), .mem_addr(mem_addr), .if_data(if_data), .mem_data(mem_data),
    .if_data_valid(if_data_valid), .mem_data_valid(mem_data_valid),
    .if_beat(if_beat), .mem_beat(mem_beat), .if_done(if_done), .mem_done(mem_done),
    .if_err(if_err), .mem_err(mem_err), .m_axi(m_axi)
  );
  always #5 clk = ~clk;
  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction
  // reference arbitration rule: a lone request wins, a tie goes to whoever was not served last
  function automatic int pick(logic i, logic m);
    if (i && m) return 1 - model_last;
    return m ? 1 : 0;
  endfunction
  task automatic finish_run();
    chk("ar_q_drain", ar_q.size(), 0);
    chk("beat_q_drain", beat_q.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  endtask
  always @(negedge clk) begin
    ar_t a;
    beat_t b;
    if (reset) begin
      if (m_axi.arvalid && m_axi.arready) begin
        chk("ar_expected", ar_q.size() > 0, 1);
        if (ar_q.size() > 0) begin
          a = ar_q.pop_front();
          chk("arid", m_axi.arid, a.id);
          chk("araddr", m_axi.araddr, a.addr);
          chk("ar_const", {m_axi.arlen, m_axi.arsize, m_axi.arburst, m_axi.arlock, m_axi.arcache, m_axi.arprot},
              {8'd7, 3'b011, 2'b01, 1'b0, 4'd0, 3'd0});
        end
      end
      if (if_data_valid || mem_data_valid) begin
        chk("beat_expected", beat_q.size() > 0, 1);
        if (beat_q.size() > 0) begin
          b = beat_q.pop_front();
          chk("beat_owner", {mem_data_valid, if_data_valid}, b.own != 0 ? 2'b10 : 2'b01);
          chk("beat_data", b.own != 0 ? mem_data : if_data, b.data);
          chk("beat_idx", b.own != 0 ? mem_beat : if_beat, b.idx);
          chk("beat_done", b.own != 0 ? mem_done : if_done, b.last);
          chk("beat_err", b.own != 0 ? mem_err : if_err, b.err);
          chk("beat_other_quiet", b.own != 0 ? {if_data, if_beat, if_done, if_err} : {mem_data, mem_beat, mem_done, mem_err}, 0);
        end
      end
      if ((if_done && !if_data_valid) || (mem_done && !mem_data_valid)) chk("done_stray", {if_done, mem_done}, 0);
    end
  end
  task automatic do_reset(input int own);
    #1 chk("pre_reset_valid", own != 0 ? mem_data_valid : if_data_valid, 1);
    #1 reset = 0;
    #1;
    chk("rst_async_ar", {m_axi.arvalid, m_axi.rready, m_axi.araddr, m_axi.arid}, 0);
    chk("rst_async_if", {if_data_valid, if_done, if_err, if_beat, if_data}, 0);
    chk("rst_async_mem", {mem_data_valid, mem_done, mem_err, mem_beat, mem_data}, 0);
    if_req = 0;
    mem_req = 0;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1;
    @(negedge clk);
    chk("rready_after_reset", m_axi.rready, 0);
    @(posedge clk); #1 m_axi.rvalid = 0;
    m_axi.rlast = 0;
    model_last = 0;
  endtask
  task automatic run_txn(input int stall, input int nbeats, input int gap, input int err_beat,
                         input int bad_at, input int reset_at, input int base, input bit early_drop);
    int own, n, acc;
    bit stk, lst;
    logic [1:0] resp;
    logic [63:0] d, exp_addr;
    own = pick(if_req, mem_req);
    exp_addr = (own != 0 ? mem_addr : if_addr) & ~64'h3f;
    ar_q.push_back('{own, exp_addr});
    n = 0;
    do begin @(negedge clk); n++; end while (!m_axi.arvalid && n < 20);
    chk("ar_latency", n, 2);
    if (!m_axi.arvalid) finish_run();
    for (int k = 0; k < stall; k++) begin
      chk("ar_hold_valid", m_axi.arvalid, 1);
      chk("ar_hold_addr", m_axi.araddr, exp_addr);
      chk("ar_hold_id", m_axi.arid, own);
      @(negedge clk);
    end
    @(posedge clk); #1 m_axi.arready = 1;
    @(posedge clk); #1 m_axi.arready = 0;
    @(negedge clk);
    chk("data_rready", m_axi.rready, 1);
    chk("data_arvalid_low", m_axi.arvalid, 0);
    @(posedge clk); #1;
    acc = 0;
    stk = 0;
    for (int i = 0; i < nbeats; i++) begin
      repeat (gap) begin @(posedge clk); #1; end
      if (i == bad_at) begin
        m_axi.rid = 13'd5;
        m_axi.rdata = {$urandom, $urandom};
        m_axi.rresp = 2'b00;
        m_axi.rlast = 0;
        m_axi.rvalid = 1;
        stk = 1;
        @(posedge clk); #1 m_axi.rvalid = 0;
      end
      resp = i == err_beat ? 2'b10 : 2'b00;
      lst = i == nbeats - 1;
      d = base != 0 ? 64'(base + i) : {$urandom, $urandom};
      m_axi.rid = 13'(own);
      m_axi.rdata = d;
      m_axi.rresp = resp;
      m_axi.rlast = lst;
      m_axi.rvalid = 1;
      if (i == reset_at) begin
        do_reset(own);
        return;
      end
      stk = stk || resp != 2'b00;
      beat_q.push_back('{own, d, acc % BL, lst, lst && (stk || acc % BL != BL - 1)});
      acc++;
      if (early_drop && i == 0) begin
        if (own != 0) mem_req = 0;
        else if_req = 0;
      end
      @(posedge clk); #1 m_axi.rvalid = 0;
      m_axi.rlast = 0;
    end
    if (own != 0) mem_req = 0;
    else if_req = 0;
    model_last = own;
  endtask
  initial begin
    #500000;
    checks++;
    fails++;
    $display("FAIL watchdog: run did not complete");
    finish_run();
  end
  initial begin
    logic [1:0] r;
    m_axi.arready = 0;
    m_axi.rvalid = 0;
    m_axi.rlast = 0;
    m_axi.rid = 0;
    m_axi.rdata = 0;
    m_axi.rresp = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ar", {m_axi.arvalid, m_axi.rready, m_axi.araddr, m_axi.arid}, 0);
    chk("rst_out", {if_data_valid, if_done, if_err, if_beat, mem_data_valid, mem_done, mem_err, mem_beat}, 0);
    reset = 1;
    @(posedge clk); #1;
    if_req = 1;
    if_addr = 64'h1000_0038;
    run_txn(0, 8, 0, -1, -1, -1, 'hA0, 0);
    if_req = 1;
    mem_req = 1;
    if_addr = {$urandom, $urandom};
    mem_addr = {$urandom, $urandom};
    run_txn(1, 8, 0, -1, -1, -1, 0, 0);
    run_txn(0, 8, 1, -1, -1, -1, 0, 0);
    if_req = 1;
    mem_req = 1;
    run_txn(0, 8, 0, -1, -1, -1, 0, 0);
    if_req = 1;
    if_addr = {$urandom, $urandom};
    run_txn(5, 8, 0, -1, -1, -1, 0, 0);
    mem_req = 1;
    mem_addr = {$urandom, $urandom};
    run_txn(0, 8, 2, 3, -1, -1, 0, 0);
    if_req = 1;
    run_txn(0, 8, 0, -1, 3, -1, 0, 0);
    mem_req = 1;
    run_txn(0, 6, 0, -1, -1, -1, 0, 0);
    if_req = 1;
    run_txn(0, 8, 0, -1, -1, 4, 0, 0);
    if_req = 1;
    if_addr = {$urandom, $urandom};
    run_txn(0, 8, 0, -1, -1, -1, 0, 0);
    repeat (25) begin
      r = 2'($urandom_range(1, 3));
      if_req = r[0];
      mem_req = r[1];
      if_addr = {$urandom, $urandom};
      mem_addr = {$urandom, $urandom};
      run_txn($urandom_range(0, 3), $urandom_range(0, 3) == 0 ? $urandom_range(1, 16) : 8,
              $urandom_range(0, 2), $urandom_range(0, 15), $urandom_range(0, 19), -1, 0,
              1'($urandom_range(0, 1)));
    end
    repeat (3) @(posedge clk);
    finish_run();
  end
endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Shares the core's single AXI read channel (AR/R) between two line-fill requesters: instruction fetch (IF) and the memory stage (MEM).
- Grants one requester at a time and issues one INCR burst per request.
- Steers the returned R beats back to the granted requester and signals completion and error status.
- Sits directly below the fetch and memory-handler stages; the top level connects its m_axi_ar*/m_axi_r* ports to the bus.

Parameters:
- ID_WIDTH, 13, AXI ID width.
- ADDR_WIDTH, 64, AXI address width.
- DATA_WIDTH, 64, AXI data width; one beat is 8 bytes.
- BURST_LEN, 8, beats per line fill; power of two, 1..16; line = BURST_LEN*8 bytes.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- if_req, mem_req  in  1 each  request; held high until that requester's done pulse.
- if_addr, mem_addr  in  ADDR_WIDTH each  byte address inside the requested line.
- if_data, mem_data  out  DATA_WIDTH each  returned beat data.
- if_data_valid, mem_data_valid  out  1 each  beat strobe to the owner.
- if_beat, mem_beat  out  $clog2(BURST_LEN) each  index of the current beat.
- if_done, mem_done  out  1 each  one-cycle pulse on the final beat.
- if_err, mem_err  out  1 each  valid with done; 1 = error in the burst.
- m_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  AXI AR channel.
- m_axi_arready  in  1.
- m_axi_rid/rdata/rresp/rlast/rvalid  in  AXI R channel.
- m_axi_rready  out  1.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, rr_last=IF, all outputs 0, beat counter 0, sticky error 0.
- Reset mid-burst abandons the transaction. Beats arriving after reset is released are dropped, because rready=0 in IDLE.
- Constant AR fields:
  - arlen=BURST_LEN-1
  - arsize=3'b011
  - arburst=2'b01 (INCR)
  - arlock=0, arcache=4'b0000, arprot=3'b000
- FSM IDLE:
  - If exactly one request is high, grant it.
  - If both are high, grant the requester not equal to rr_last. Because rr_last resets to IF, MEM wins the first tie.
  - On a grant:
    - Latch owner.
    - Latch the aligned address (addr with the low $clog2(BURST_LEN*8) bits cleared).
    - Set arid={ (ID_WIDTH-1)'b0, owner }, with IF=0 and MEM=1.
    - Go to AR.
  - Registered: arvalid first rises the cycle after the request is seen.
- FSM AR:
  - arvalid=1; araddr and arid are held stable.
  - On arready: go to DATA, clear beat counter and error flag.
- FSM DATA:
  - rready=1.
  - Accepted beat = rvalid && rid==arid.
  - On an accepted beat:
    - Drive owner_data=rdata, owner_data_valid=1, owner_beat=counter (combinational from R, same cycle).
    - Increment counter.
  - err_flag |= (rresp!=2'b00).
  - An accepted beat with rlast:
    - Pulses owner_done.
    - owner_err = err_flag OR this beat's rresp!=0 OR counter!=BURST_LEN-1.
    - Sets rr_last=owner and returns to IDLE.
  - A beat that arrives with no rlast when counter==BURST_LEN-1 is still forwarded. The counter wraps, and the err condition is resolved at rlast.
  - Beats with rid!=arid are consumed (rready=1) but not forwarded, and set err_flag.
- Non-owner outputs stay 0 throughout.
- The earliest re-grant is the cycle after done, via IDLE; at most one outstanding transaction.
- A request that drops before its grant is ignored. A request that drops mid-burst does not abort: the burst completes and done still pulses.

Decomposition:
- Package axi_rd_arb_pkg holds:
  - enum arb_state_e {IDLE, AR, DATA}
  - enum requester_e {REQ_IF=0, REQ_MEM=1}
  - constants AXI_BURST_INCR=2'b01, AXI_SIZE_8B=3'b011, AXI_RESP_OKAY=2'b00
- Single module, no sub-module; round-robin pick is a few lines inline.

Test Plan:
- Single IF request, if_addr=0x1000_0038, arready immediate, 8 OKAY beats 0xA0..0xA7:
  - Expect araddr=0x1000_0000, arlen=7, arid=0.
  - if_data_valid on 8 beats with if_beat 0..7.
  - if_done with rlast, if_err=0, mem_* stay 0.
- if_req and mem_req both rise the first cycle after reset:
  - MEM is served first (arid=1), then IF (arid=0).
  - A third tie with both high is served by MEM.
- arready held low for 5 cycles in AR: arvalid stays 1, and araddr/arid are stable all 5 cycles; DATA is entered on the arready cycle.
- rvalid gaps of 2 cycles between beats, rresp=2'b10 on beat 3: all 8 beats forwarded, mem_err=1 with mem_done.
- Async reset asserted during beat 4: all outputs go 0 immediately; after release a new IF request yields arvalid the next cycle.
- Beat with rid=5 injected mid-burst: not forwarded, beat index unchanged, done carries err=1.
- rlast on beat 6: done pulses and err=1.
